// File: rtl/cmp_share_arbiter_pkg.sv
// Package: cmp_share_arbiter_pkg
// Purpose: shared constants for the compare/subtract sharing block:
//   default datapath width, op encoding and the signed less-than fix-up.
// Contents:
//   DEF_DATA_W  default operand/result width
//   OP_SUB      op code for A-B
//   OP_SLT      op code for signed A<B
//   slt_fix     signed less-than from operand MSBs and the difference MSB
package cmp_share_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 64;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_SLT = 1'b1;

    // When the signs differ the subtraction may overflow, so the sign of A alone
    // decides; otherwise the sign of the difference is exact.
    function automatic logic slt_fix(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) ? a_msb : d_msb;
    endfunction

endpackage

// File: rtl/cmp_share_arbiter_rr_arbiter.sv
// Module: cmp_share_arbiter_rr_arbiter
// Purpose: round-robin arbiter with its own rotating priority pointer.
//   Grants the first asserted request scanning upward from the pointer,
//   wrapping modulo NUM_REQ. The pointer moves past the winner only when a
//   grant is issued.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (pointer -> 0)
//   req      in   request vector
//   en       in   grant enable; no grant while low
//   gnt      out  one-hot grant (or zero)
//   gnt_idx  out  index of the granted request
//   gnt_any  out  a grant is issued this cycle
module cmp_share_arbiter_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        if (en) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
                if (!gnt_any && req[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                    gnt_any   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Module: cmp_share_arbiter
// Purpose: shares one subtract / signed-compare datapath among NUM_REQ
//   requesters with round-robin arbitration and a registered, one-deep,
//   ID-tagged response.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   per-requester request valid
//   req_ready  out  per-requester accept, one-hot or zero
//   req_op     in   per-requester op (OP_SUB / OP_SLT)
//   req_a      in   packed operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b      in   packed operand B, same packing
//   rsp_valid  out  response valid
//   rsp_ready  in   downstream accepts response
//   rsp_id     out  requester index that issued the response
//   rsp_data   out  SUB: A-B wrapped; SLT: zero-extended signed A<B
module cmp_share_arbiter
    import cmp_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    logic               slot_free;
    logic               grant_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               xfer;

    logic [DATA_W-1:0]  sel_a, sel_b, diff, result;
    logic               sel_op, lt;

    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    // The response register is the only buffer, so a new grant needs it empty
    // or draining this cycle.
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign grant_en  = slot_free && !rst;

    cmp_share_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (grant_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (xfer)
    );

    // Grants only go to valid requesters, so ready implies a transfer.
    assign req_ready = gnt;

    always_comb begin
        sel_a  = req_a[32'(gnt_idx) * DATA_W +: DATA_W];
        sel_b  = req_b[32'(gnt_idx) * DATA_W +: DATA_W];
        sel_op = req_op[gnt_idx];
        diff   = sel_a + ~sel_b + DATA_W'(1);
        lt     = slt_fix(sel_a[DATA_W-1], sel_b[DATA_W-1], diff[DATA_W-1]);
        result = (sel_op == OP_SLT) ? {{(DATA_W-1){1'b0}}, lt} : diff;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx;
            rsp_data_d  = result;
        end else if (rsp_ready) begin
            // Drain without refill: data is held, only valid drops.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Testbench for cmp_share_arbiter: directed vectors, scoreboard queue filled by
// the stimulus side, drained by an independent response monitor.
module tb_cmp_share_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_op;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    cmp_share_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [63:0] data);
        exp_t e;
        e.id   = IW'(id);
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic op, input logic [63:0] a,
                           input logic [63:0] b);
        req_op[i]         = op;
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic issue(input int i, input logic op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        bit got;
        got = 1'b0;
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        #1;
        for (int c = 0; c < 20 && !got; c++) begin
            if (req_ready[i]) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("grant", 64'(req_ready), 64'(1 << i));
        if (got) begin
            push(i, exp);
            @(posedge clk);
            #1;
            check("latency_valid", 64'(rsp_valid), 64'd1);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    // Response monitor: samples well before the rising edge that consumes it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d data %h, expected none",
                             rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] MIN_S = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX_S = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [63:0] rr_a[N]   = '{64'd1000, 64'd2000, 64'd3000, 64'hFFFF_FFFF_FFFF_FFFB};
    logic [63:0] rr_b[N]   = '{64'd1, 64'd2, 64'd3, 64'd3};
    logic        rr_op[N]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] rr_exp[N] = '{64'd999, 64'd1998, 64'd2997, 64'd1};

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset: ready must stay low even with every requester valid.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check("ready_in_reset", 64'(req_ready), 64'd0);
        end
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_id", 64'(rsp_id), 64'd0);
        check("reset_data", rsp_data, 64'd0);

        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("idle_valid", 64'(rsp_valid), 64'd0);
            check("idle_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end

        // Single transactions.
        issue(0, 1'b0, 64'd10, 64'd3, 64'd7);
        issue(2, 1'b1, MIN_S, 64'd1, 64'd1);
        issue(2, 1'b1, 64'd1, MIN_S, 64'd0);
        issue(2, 1'b1, 64'd5, 64'd5, 64'd0);
        issue(1, 1'b0, 64'd0, 64'd1, ONES);
        issue(3, 1'b1, MAX_S, ONES, 64'd0);
        issue(1, 1'b1, MIN_S, MAX_S, 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("drain_valid", 64'(rsp_valid), 64'd0);

        // Round robin from a fresh pointer, all requesters valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, rr_op[i], rr_a[i], rr_b[i]);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_grant", 64'(req_ready), 64'(1 << (k % N)));
            push(k % N, rr_exp[k % N]);
            if (k > 0) check("rr_no_bubble", 64'(rsp_valid), 64'd1);
            @(negedge clk);
        end

        // Stall: last response (requester 3) held, no grants.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_id", 64'(rsp_id), 64'd3);
            check("stall_data", rsp_data, rr_exp[3]);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("resume_grant", 64'(req_ready), 64'(1 << k));
            push(k, rr_exp[k]);
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("rr_drain_valid", 64'(rsp_valid), 64'd0);

        // Reset while a response is pending and requester 1 is still valid.
        set_req(1, 1'b0, 64'd77, 64'd7);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check("pre_reset_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("pending_valid", 64'(rsp_valid), 64'd1);
        check("ready_mid_reset", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("reset_drop", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 1'b0, 64'd50, 64'd8);
        req_valid = 4'b0011;
        #1;
        check("post_reset_grant", 64'(req_ready), 64'b0001);
        push(0, 64'd42);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("post_reset_next", 64'(req_ready), 64'b0010);
        push(1, 64'd70);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #3;
        check("final_valid", 64'(rsp_valid), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
